// File: rtl/fpmul_pkg.sv
// Shared types and constants for the binary32 multiplier normalise/round/pack stage.
package fpmul_pkg;

    localparam int MW   = 24;
    localparam int EW   = 8;
    localparam int BIAS = 127;

    localparam logic signed [9:0] EXP_MAX = 10'sd255;
    localparam logic [31:0]       QNAN    = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        SPEC_NORM = 2'b00,
        SPEC_ZERO = 2'b01,
        SPEC_INF  = 2'b10,
        SPEC_NAN  = 2'b11
    } spec_t;

    // Normalised operand held between the two pipeline stages.
    typedef struct packed {
        logic              sgn;
        spec_t             spec;
        logic signed [9:0] e;
        logic [22:0]       mant;
        logic              g;
        logic              st;
    } s1_t;

endpackage

// File: rtl/fpmul_rne_round.sv
// Combinational round-to-nearest-even, exponent adjust and binary32 pack with
// overflow-to-inf and flush-to-zero. Flag output exists only with FPMUL_EXC_FLAGS_EN.
module fpmul_rne_round
    import fpmul_pkg::*;
(
    input  s1_t         s1,
    output logic [31:0] res
`ifdef FPMUL_EXC_FLAGS_EN
    ,
    output logic [2:0]  flg
`endif
);

    logic              round_up;
    logic [23:0]       mant_r;
    logic signed [9:0] e_r;

    // A carry out of the rounded mantissa leaves the fraction at zero and bumps the exponent.
    always_comb begin
        round_up = s1.g & (s1.st | s1.mant[0]);
        mant_r   = {1'b0, s1.mant} + {23'b0, round_up};
        e_r      = s1.e + (mant_r[23] ? 10'sd1 : 10'sd0);
        res      = '0;
`ifdef FPMUL_EXC_FLAGS_EN
        flg      = 3'b000;
`endif
        case (s1.spec)
            SPEC_ZERO: res = {s1.sgn, 31'b0};
            SPEC_INF:  res = {s1.sgn, 8'hFF, 23'b0};
            SPEC_NAN:  res = QNAN;
            default: begin
                if (e_r >= EXP_MAX) begin
                    res = {s1.sgn, 8'hFF, 23'b0};
`ifdef FPMUL_EXC_FLAGS_EN
                    flg[2] = 1'b1;
`endif
                end else if (e_r <= 10'sd0) begin
                    res = {s1.sgn, 31'b0};
`ifdef FPMUL_EXC_FLAGS_EN
                    flg[1] = 1'b1;
`endif
                end else begin
                    res = {s1.sgn, e_r[7:0], mant_r[22:0]};
                end
`ifdef FPMUL_EXC_FLAGS_EN
                flg[0] = s1.g | s1.st;
`endif
            end
        endcase
    end

endmodule

// File: rtl/fpmul_normround.sv
// Two-stage valid/ready pipeline: normalise the 48-bit mantissa product, then RNE-round and pack
// to binary32. Defining FPMUL_EXC_FLAGS_EN adds out_flg/sticky_flg exception flags and flg_clr.
module fpmul_normround
    import fpmul_pkg::*;
#(
    parameter int MW   = 24,
    parameter int EW   = 8,
    parameter int BIAS = 127
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_vld,
    output logic            in_rdy,
    input  logic            in_sgn,
    input  logic [EW-1:0]   in_expa,
    input  logic [EW-1:0]   in_expb,
    input  logic [1:0]      in_spec,
    input  logic [2*MW-1:0] in_prod,
    output logic            out_vld,
    input  logic            out_rdy,
    output logic [31:0]     out_res
`ifdef FPMUL_EXC_FLAGS_EN
    ,
    input  logic            flg_clr,
    output logic [2:0]      out_flg,
    output logic [2:0]      sticky_flg
`endif
);

    localparam logic signed [EW+1:0] BIAS_E = (EW+2)'(BIAS);

    logic              s1_vld;
    logic              s1_adv;
    s1_t               s1;
    s1_t               s1_next;
    logic signed [EW+1:0] e_sum;
    logic [31:0]       rnd_res;

    assign s1_adv = !out_vld | out_rdy;
    assign in_rdy = !s1_vld | s1_adv;

    // A product of 2.0 or more has its leading one at the top bit and needs one extra exponent step.
    always_comb begin
        e_sum        = $signed({2'b00, in_expa}) + $signed({2'b00, in_expb}) - BIAS_E;
        s1_next.sgn  = in_sgn;
        s1_next.spec = spec_t'(in_spec);
        if (in_prod[2*MW-1]) begin
            s1_next.e    = e_sum + 10'sd1;
            s1_next.mant = in_prod[2*MW-2 -: MW-1];
            s1_next.g    = in_prod[MW-1];
            s1_next.st   = |in_prod[MW-2:0];
        end else begin
            s1_next.e    = e_sum;
            s1_next.mant = in_prod[2*MW-3 -: MW-1];
            s1_next.g    = in_prod[MW-2];
            s1_next.st   = |in_prod[MW-3:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s1     <= '0;
        end else if (in_rdy) begin
            s1_vld <= in_vld;
            if (in_vld)
                s1 <= s1_next;
        end
    end

`ifdef FPMUL_EXC_FLAGS_EN
    logic [2:0] rnd_flg;

    fpmul_rne_round u_round (
        .s1  (s1),
        .res (rnd_res),
        .flg (rnd_flg)
    );
`else
    fpmul_rne_round u_round (
        .s1  (s1),
        .res (rnd_res)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld <= 1'b0;
            out_res <= '0;
        end else if (s1_adv) begin
            out_vld <= s1_vld;
            if (s1_vld)
                out_res <= rnd_res;
        end
    end

`ifdef FPMUL_EXC_FLAGS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            out_flg <= 3'b000;
        else if (s1_adv && s1_vld)
            out_flg <= rnd_flg;
    end

    // Clear has priority over a flag set arriving in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sticky_flg <= 3'b000;
        else if (flg_clr)
            sticky_flg <= 3'b000;
        else if (out_vld && out_rdy)
            sticky_flg <= sticky_flg | out_flg;
    end
`endif

endmodule

// File: tb/tb_fpmul_normround.sv
// Directed-vector bench for fpmul_normround: arithmetic, rounding, range limits, specials,
// throughput, backpressure and mid-flight reset.
module tb_fpmul_normround;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_vld = 1'b0;
    logic        in_rdy;
    logic        in_sgn = 1'b0;
    logic [7:0]  in_expa = '0;
    logic [7:0]  in_expb = '0;
    logic [1:0]  in_spec = '0;
    logic [47:0] in_prod = '0;
    logic        out_vld;
    logic        out_rdy = 1'b1;
    logic [31:0] out_res;
`ifdef FPMUL_EXC_FLAGS_EN
    logic        flg_clr = 1'b0;
    logic [2:0]  out_flg;
    logic [2:0]  sticky_flg;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fpmul_normround dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .in_sgn  (in_sgn),
        .in_expa (in_expa),
        .in_expb (in_expb),
        .in_spec (in_spec),
        .in_prod (in_prod),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .out_res (out_res)
`ifdef FPMUL_EXC_FLAGS_EN
        ,
        .flg_clr    (flg_clr),
        .out_flg    (out_flg),
        .sticky_flg (sticky_flg)
`endif
    );

    // Push one beat, wait for its result; lat counts negedges after the accepting edge (-1 on timeout).
    task automatic run_single(input logic sgn, input logic [7:0] ea, input logic [7:0] eb,
                              input logic [1:0] sp, input logic [47:0] prod,
                              output logic [31:0] res, output int lat);
        int guard;
        @(negedge clk);
        out_rdy = 1'b1;
        in_vld  = 1'b1;
        in_sgn  = sgn;
        in_expa = ea;
        in_expb = eb;
        in_spec = sp;
        in_prod = prod;
        guard = 0;
        while (!in_rdy && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        in_vld = 1'b0;
        lat = 1;
        while (!out_vld && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        res = out_res;
        if (!out_vld)
            lat = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (out_vld !== 1'b0 || out_res !== 32'h0) begin
            bad++;
            $display("FAIL reset_out: got vld=%b res=%h want vld=0 res=00000000", out_vld, out_res);
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (in_rdy !== 1'b1 || out_vld !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: got in_rdy=%b out_vld=%b want 1 0", in_rdy, out_vld);
        end
    endtask

    task automatic test_normal();
        logic [7:0]  ea  [5] = '{8'd127, 8'd127, 8'd127, 8'd128, 8'd127};
        logic [7:0]  eb  [5] = '{8'd127, 8'd127, 8'd127, 8'd127, 8'd127};
        logic        sg  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [47:0] pr  [5] = '{48'h4000_0000_0000, 48'h9000_0000_0000, 48'h6000_0000_0000,
                                 48'h8000_0000_0000, 48'h4000_0000_0000};
        logic [31:0] exv [5] = '{32'h3F80_0000, 32'h4010_0000, 32'h3FC0_0000,
                                 32'h4080_0000, 32'hBF80_0000};
        logic [31:0] res;
        int lat;
        for (int i = 0; i < 5; i++) begin
            run_single(sg[i], ea[i], eb[i], 2'b00, pr[i], res, lat);
            total++;
            if (res !== exv[i]) begin
                bad++;
                $display("FAIL normal_%0d: got %h want %h", i, res, exv[i]);
            end
            if (i == 0) begin
                total++;
                if (lat != 2) begin
                    bad++;
                    $display("FAIL latency: got %0d want 2", lat);
                end
            end
        end
    endtask

    task automatic test_rounding();
        logic [47:0] pr  [7] = '{48'h4000_0040_0000, 48'h4000_00C0_0000, 48'h4000_0060_0000,
                                 48'h4000_0020_0000, 48'h7FFF_FFC0_0000, 48'h8000_0080_0000,
                                 48'h8000_0180_0000};
        logic [31:0] exv [7] = '{32'h3F80_0000, 32'h3F80_0002, 32'h3F80_0001,
                                 32'h3F80_0000, 32'h4000_0000, 32'h4000_0000,
                                 32'h4000_0002};
        logic [31:0] res;
        int lat;
        for (int i = 0; i < 7; i++) begin
            run_single(1'b0, 8'd127, 8'd127, 2'b00, pr[i], res, lat);
            total++;
            if (res !== exv[i]) begin
                bad++;
                $display("FAIL round_%0d: got %h want %h", i, res, exv[i]);
            end
        end
    endtask

    task automatic test_range();
        logic [7:0]  ea  [7] = '{8'd254, 8'd254, 8'd254, 8'd1, 8'd1, 8'd1, 8'd1};
        logic [7:0]  eb  [7] = '{8'd254, 8'd128, 8'd127, 8'd1, 8'd126, 8'd126, 8'd127};
        logic        sg  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [47:0] pr  [7] = '{48'h4000_0000_0000, 48'h4000_0000_0000, 48'h4000_0000_0000,
                                 48'h4000_0000_0000, 48'h4000_0000_0000, 48'h8000_0000_0000,
                                 48'h4000_0000_0000};
        logic [31:0] exv [7] = '{32'h7F80_0000, 32'h7F80_0000, 32'h7F00_0000, 32'h8000_0000,
                                 32'h0000_0000, 32'h0080_0000, 32'h0080_0000};
        logic [31:0] res;
        int lat;
        for (int i = 0; i < 7; i++) begin
            run_single(sg[i], ea[i], eb[i], 2'b00, pr[i], res, lat);
            total++;
            if (res !== exv[i]) begin
                bad++;
                $display("FAIL range_%0d: got %h want %h", i, res, exv[i]);
            end
        end
    endtask

    task automatic test_specials();
        logic [1:0]  sp  [5] = '{2'b01, 2'b10, 2'b10, 2'b11, 2'b01};
        logic        sg  [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [7:0]  ea  [5] = '{8'd127, 8'd3, 8'd127, 8'd127, 8'd254};
        logic [47:0] pr  [5] = '{48'h9000_0000_0000, 48'h4000_0000_0000, 48'h7FFF_FFFF_FFFF,
                                 48'h4000_0000_0000, 48'hC000_0000_0000};
        logic [31:0] exv [5] = '{32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
                                 32'h7FC0_0000, 32'h0000_0000};
        logic [31:0] res;
        int lat;
        for (int i = 0; i < 5; i++) begin
            run_single(sg[i], ea[i], ea[i], sp[i], pr[i], res, lat);
            total++;
            if (res !== exv[i]) begin
                bad++;
                $display("FAIL special_%0d: got %h want %h", i, res, exv[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exv [4];
        int ocnt = 0;
        int first_c = -1;
        out_rdy = 1'b1;
        for (int k = 0; k < 4; k++)
            exv[k] = 32'h3F80_0000 + (32'(k) << 23);
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (out_vld) begin
                if (first_c < 0)
                    first_c = c;
                total++;
                if (ocnt >= 4 || out_res !== exv[ocnt & 3]) begin
                    bad++;
                    $display("FAIL b2b_data_%0d: got %h want %h", ocnt, out_res, exv[ocnt & 3]);
                end
                ocnt++;
            end
            if (c < 4) begin
                total++;
                if (in_rdy !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b_in_rdy_%0d: got %b want 1", c, in_rdy);
                end
                in_vld  = 1'b1;
                in_sgn  = 1'b0;
                in_spec = 2'b00;
                in_expa = 8'(127 + c);
                in_expb = 8'd127;
                in_prod = 48'h4000_0000_0000;
            end else begin
                in_vld = 1'b0;
            end
        end
        total++;
        if (ocnt != 4 || first_c != 2) begin
            bad++;
            $display("FAIL b2b_count: got count=%0d first=%0d want count=4 first=2", ocnt, first_c);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exv [2] = '{32'h3F80_0000, 32'h4000_0000};
        int acc = 0;
        int ocnt = 0;
        @(negedge clk);
        out_rdy = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            if (c >= 3) begin
                total++;
                if (out_vld !== 1'b1 || out_res !== exv[0]) begin
                    bad++;
                    $display("FAIL bp_hold_%0d: got vld=%b res=%h want vld=1 res=%h",
                             c, out_vld, out_res, exv[0]);
                end
            end
            in_vld  = 1'b1;
            in_sgn  = 1'b0;
            in_spec = 2'b00;
            in_expa = 8'(127 + acc);
            in_expb = 8'd127;
            in_prod = 48'h4000_0000_0000;
            if (in_rdy)
                acc++;
        end
        @(negedge clk);
        total++;
        if (acc != 2 || in_rdy !== 1'b0) begin
            bad++;
            $display("FAIL bp_accept: got accepted=%0d in_rdy=%b want accepted=2 in_rdy=0", acc, in_rdy);
        end
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (out_vld) begin
                total++;
                if (ocnt >= 2 || out_res !== exv[ocnt & 1]) begin
                    bad++;
                    $display("FAIL bp_drain_%0d: got %h want %h", ocnt, out_res, exv[ocnt & 1]);
                end
                ocnt++;
            end
            @(negedge clk);
        end
        total++;
        if (ocnt != 2) begin
            bad++;
            $display("FAIL bp_drain_count: got %0d want 2", ocnt);
        end
    endtask

    task automatic test_reset_midflight();
        int stale = 0;
        logic [31:0] res;
        int lat;
        @(negedge clk);
        out_rdy = 1'b0;
        for (int c = 0; c < 2; c++) begin
            if (c > 0) @(negedge clk);
            in_vld  = 1'b1;
            in_spec = 2'b00;
            in_expa = 8'(130 + c);
            in_expb = 8'd127;
            in_prod = 48'h4000_0000_0000;
        end
        @(negedge clk);
        in_vld = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (out_vld !== 1'b0 || out_res !== 32'h0) begin
            bad++;
            $display("FAIL midreset_async: got vld=%b res=%h want vld=0 res=00000000", out_vld, out_res);
        end
        @(negedge clk);
        rst_n   = 1'b1;
        out_rdy = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_vld)
                stale++;
        end
        total++;
        if (stale != 0) begin
            bad++;
            $display("FAIL midreset_stale: got %0d stale beats want 0", stale);
        end
        run_single(1'b0, 8'd127, 8'd127, 2'b00, 48'h9000_0000_0000, res, lat);
        total++;
        if (res !== 32'h4010_0000) begin
            bad++;
            $display("FAIL midreset_recover: got %h want 40100000", res);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_rounding();
        test_range();
        test_specials();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
